// File: rtl/sine_seq_ctrl.sv
// Burst sequencer for the magic-circle sine oscillator: paces osc_en, counts samples, registers output.
// Optional macro SINE_CTRL_PHASE_RESET_EN inserts a one-cycle RESTART that rephases the oscillator.
module sine_seq_ctrl #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [DIV_W-1:0]    rate_div,
    input  logic [CNT_W-1:0]    num_samples,
    input  logic signed [19:0]  sine_in,
    output logic                osc_en,
    output logic                osc_rst_n,
    output logic                busy,
    output logic                done,
    output logic signed [19:0]  sample_out,
    output logic                sample_valid
);

    typedef enum logic [1:0] {
        StIdle,
        StRestart,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  rate_div_q, rate_div_d;
    logic [CNT_W-1:0]  num_samples_q, num_samples_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic signed [19:0] sample_out_q, sample_out_d;
    logic              sample_valid_q;

    logic [CNT_W-1:0]  smp_cnt_inc;
    logic              step_hit;
    logic              last_sample;

    assign smp_cnt_inc = smp_cnt_q + CNT_W'(1);
    assign step_hit    = (div_cnt_q == rate_div_q);
    // num_samples of zero means run until stop, so never completes
    assign last_sample = (num_samples_q != '0) && (smp_cnt_inc == num_samples_q);

    always_comb begin
        state_d       = state_q;
        rate_div_d    = rate_div_q;
        num_samples_d = num_samples_q;
        div_cnt_d     = div_cnt_q;
        smp_cnt_d     = smp_cnt_q;
        sample_out_d  = sample_out_q;
        osc_en        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
`ifdef SINE_CTRL_PHASE_RESET_EN
                    state_d = StRestart;
`else
                    state_d = StRun;
`endif
                    rate_div_d    = rate_div;
                    num_samples_d = num_samples;
                    div_cnt_d     = '0;
                    smp_cnt_d     = '0;
                end
            end
            StRestart: begin
                busy    = 1'b1;
                state_d = stop ? StIdle : StRun;
            end
            StRun: begin
                busy = 1'b1;
                if (stop) begin
                    state_d = StIdle;
                end else if (step_hit) begin
                    osc_en       = 1'b1;
                    div_cnt_d    = '0;
                    smp_cnt_d    = smp_cnt_inc;
                    sample_out_d = sine_in;
                    if (last_sample) begin
                        state_d = StDone;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            rate_div_q     <= '0;
            num_samples_q  <= '0;
            div_cnt_q      <= '0;
            smp_cnt_q      <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rate_div_q     <= rate_div_d;
            num_samples_q  <= num_samples_d;
            div_cnt_q      <= div_cnt_d;
            smp_cnt_q      <= smp_cnt_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= osc_en;
        end
    end

`ifdef SINE_CTRL_PHASE_RESET_EN
    assign osc_rst_n = ~reset & (state_q != StRestart);
`else
    assign osc_rst_n = ~reset;
`endif

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Scoreboard bench for sine_seq_ctrl: burst schedules are computed per burst from timing rules
// and checked by an independent negedge monitor; sine_in is a known function of the cycle count.
module tb_sine_seq_ctrl;

`ifdef SINE_CTRL_PHASE_RESET_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NEVER = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] rate_div = '0;
    logic [15:0] num_samples = '0;
    logic [19:0] sine_in = '0;
    logic        osc_en, osc_rst_n, busy, done, sample_valid;
    logic [19:0] sample_out;

    always #5 clk = ~clk;

    sine_seq_ctrl #(.DIV_W(16), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .rate_div     (rate_div),
        .num_samples  (num_samples),
        .sine_in      (sine_in),
        .osc_en       (osc_en),
        .osc_rst_n    (osc_rst_n),
        .busy         (busy),
        .done         (done),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    typedef struct {
        int          c;
        logic [19:0] v;
    } ev_t;

    ev_t q_en[$];
    ev_t q_smp[$];
    ev_t q_done[$];
    ev_t q_rst[$];
    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;
    int  bz_lo = 1;
    int  bz_hi = 0;

    function automatic void chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", nm, c, act, exp);
    endfunction

    function automatic logic [19:0] hsh(int c);
        logic [31:0] x;
        x = 32'(c) * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        return x[19:0];
    endfunction

    function automatic bit pop_ev(int kind, output ev_t e);
        e = '{c: -1, v: '0};
        case (kind)
            0: if (q_en.size() != 0) e = q_en.pop_front(); else return 1'b0;
            1: if (q_smp.size() != 0) e = q_smp.pop_front(); else return 1'b0;
            2: if (q_done.size() != 0) e = q_done.pop_front(); else return 1'b0;
            default: if (q_rst.size() != 0) e = q_rst.pop_front(); else return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // An empty queue leaves e.c at -1, so an unexpected pulse shows as a cycle mismatch
    function automatic void observe(int kind, string nm, logic [19:0] v);
        ev_t e;
        void'(pop_ev(kind, e));
        chk({nm, "_cycle"}, cyc, 32'(cyc), 32'(e.c));
        if (kind == 1) chk({nm, "_value"}, cyc, 32'(v), 32'(e.v));
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (osc_en) observe(0, "osc_en", '0);
            if (sample_valid) observe(1, "sample", sample_out);
            if (done) observe(2, "done", '0);
            if (!osc_rst_n) observe(3, "osc_rst_n", '0);
            chk("busy", cyc, 32'(busy), 32'(cyc >= bz_lo && cyc <= bz_hi));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sine_in = hsh(cyc);
    endtask

    task automatic gap(int k);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < k; i++) step();
    endtask

    // stop_off / rst_off: cycle offset from the first post-start cycle, -1 for none
    task automatic run_burst(int rd, int n, int stop_off, int rst_off);
        int s, r0, t, rc, last, endc;
        bit completes;
        s    = cyc;
        r0   = s + 1 + P + rd;
        t    = (stop_off >= 0) ? s + 1 + stop_off : NEVER;
        rc   = (rst_off >= 0) ? s + 1 + rst_off : NEVER;
        last = r0 + (n - 1) * (rd + 1);
        completes = (n > 0) && (last < t) && (last < rc);
        if (P == 1 && s + 1 < rc) q_rst.push_back('{c: s + 1, v: '0});
        for (int k = 0; ; k++) begin
            int r;
            r = r0 + k * (rd + 1);
            if ((n != 0 && k >= n) || r >= t || r >= rc) break;
            q_en.push_back('{c: r, v: '0});
            if (r + 1 < rc) q_smp.push_back('{c: r + 1, v: hsh(r)});
        end
        if (completes && last + 1 < rc) q_done.push_back('{c: last + 1, v: '0});
        bz_lo = s + 1;
        bz_hi = completes ? last : ((t < rc) ? t : rc - 1);
        endc  = completes ? last + 2 : ((t < rc) ? t + 1 : rc);
        if (rc < endc) endc = rc;

        start       = 1'b1;
        stop        = 1'b0;
        rate_div    = 16'(rd);
        num_samples = 16'(n);
        step();
        while (cyc < endc) begin
            rate_div    = 16'($urandom);
            num_samples = 16'($urandom);
            start       = ($urandom_range(0, 3) == 0);
            stop        = (cyc == t);
            step();
        end
        start = 1'b0;
        stop  = 1'b0;

        if (cyc == rc) begin
            reset = 1'b1;
            #1;
            chk("rst_osc_rst_n", cyc, 32'(osc_rst_n), 32'(0));
            chk("rst_osc_en", cyc, 32'(osc_en), 32'(0));
            chk("rst_busy", cyc, 32'(busy), 32'(0));
            chk("rst_done", cyc, 32'(done), 32'(0));
            chk("rst_sample_valid", cyc, 32'(sample_valid), 32'(0));
            chk("rst_sample_out", cyc, 32'(sample_out), 32'(0));
            step();
            reset = 1'b0;
            #1;
            chk("post_rst_osc_rst_n", cyc, 32'(osc_rst_n), 32'(1));
            chk("post_rst_busy", cyc, 32'(busy), 32'(0));
            chk("post_rst_sample_out", cyc, 32'(sample_out), 32'(0));
            chk("post_rst_osc_en", cyc, 32'(osc_en), 32'(0));
        end
    endtask

    initial begin
        int rd, n, so;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_osc_rst_n", cyc, 32'(osc_rst_n), 32'(0));
        chk("reset_osc_en", cyc, 32'(osc_en), 32'(0));
        chk("reset_busy", cyc, 32'(busy), 32'(0));
        chk("reset_done", cyc, 32'(done), 32'(0));
        chk("reset_sample_out", cyc, 32'(sample_out), 32'(0));
        chk("reset_sample_valid", cyc, 32'(sample_valid), 32'(0));
        reset = 1'b0;
        gap(2);

        run_burst(0, 4, -1, -1);
        gap(1);
        run_burst(3, 2, -1, -1);
        gap(2);
        run_burst(0, 0, 19, -1);
        gap(1);

        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_busy", cyc, 32'(busy), 32'(0));
        step();
        chk("start_stop_busy2", cyc, 32'(busy), 32'(0));

        for (int i = 0; i < 40; i++) begin
            rd = $urandom_range(0, 4);
            n  = $urandom_range(0, 5);
            if (n == 0) so = $urandom_range(0, 30);
            else if ($urandom_range(0, 3) == 0) so = $urandom_range(0, n * (rd + 1) + P + 1);
            else so = -1;
            run_burst(rd, n, so, -1);
            gap($urandom_range(0, 2));
        end

        run_burst(0, 0, -1, 6);
        gap(2);
        run_burst(2, 3, -1, 4);
        gap(1);
        run_burst(1, 3, -1, -1);
        gap(4);

        chk("osc_en_left", cyc, 32'(q_en.size()), 32'(0));
        chk("sample_left", cyc, 32'(q_smp.size()), 32'(0));
        chk("done_left", cyc, 32'(q_done.size()), 32'(0));
        chk("osc_rst_n_left", cyc, 32'(q_rst.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
